// File: rtl/cordic_input_sequencer_if.sv
`default_nettype none
// ============================================================================
// cordic_input_sequencer_if -- request/issue bus between a producer, the
// sequencer and the downstream CORDIC core.            Rev 1.0
// ============================================================================
interface cordic_input_sequencer_if #(
    parameter int N_FRAC = 7
);
    logic signed [N_FRAC:0] x_i;
    logic signed [N_FRAC:0] y_i;
    logic signed [N_FRAC:0] z_i;
    logic                   data_in_valid_i;
    logic                   ready_o;
    logic                   core_done_i;
    logic signed [N_FRAC:0] x_o;
    logic signed [N_FRAC:0] y_o;
    logic signed [N_FRAC:0] z_o;
    logic                   data_out_valid_strobe_o;
    logic [1:0]             quadrant_o;
    logic                   busy_o;
    logic                   timeout_o;

    modport master (
        output x_i, y_i, z_i, data_in_valid_i, core_done_i,
        input  ready_o, x_o, y_o, z_o, data_out_valid_strobe_o,
        input  quadrant_o, busy_o, timeout_o
    );

    modport slave (
        input  x_i, y_i, z_i, data_in_valid_i, core_done_i,
        output ready_o, x_o, y_o, z_o, data_out_valid_strobe_o,
        output quadrant_o, busy_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/cordic_input_sequencer.sv
`default_nettype none
// ============================================================================
// cordic_input_sequencer -- FIFO-buffered quadrant pre-rotation front end that
// issues one operation at a time to a CORDIC core.     Rev 1.0
// ============================================================================
module cordic_input_sequencer #(
    parameter int N_FRAC         = 7,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cordic_input_sequencer_if.slave bus
);
    localparam int c_w  = N_FRAC + 1;
    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_pw = c_aw + 1;
    localparam logic signed [c_w-1:0] c_quarter     = c_w'(2 ** (N_FRAC - 1));
    localparam logic signed [c_w-1:0] c_neg_quarter = -c_quarter;
    localparam logic signed [c_w-1:0] c_max         = {1'b0, {N_FRAC{1'b1}}};
    localparam logic signed [c_w-1:0] c_min         = {1'b1, {N_FRAC{1'b0}}};
    localparam logic [7:0]            c_tmo_last    = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic signed [c_w-1:0] mem_x_q [FIFO_DEPTH];
    logic signed [c_w-1:0] mem_y_q [FIFO_DEPTH];
    logic signed [c_w-1:0] mem_z_q [FIFO_DEPTH];
    logic [c_pw-1:0]       wr_ptr_q;
    logic [c_pw-1:0]       rd_ptr_q;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    state_t                state_q;
    logic                  pend_q;
    logic signed [c_w-1:0] pend_x_q;
    logic signed [c_w-1:0] pend_y_q;
    logic signed [c_w-1:0] pend_z_q;
    logic signed [c_w-1:0] x_q;
    logic signed [c_w-1:0] y_q;
    logic signed [c_w-1:0] z_q;
    logic signed [c_w-1:0] x_d;
    logic signed [c_w-1:0] y_d;
    logic signed [c_w-1:0] z_d;
    logic [1:0]            quad_q;
    logic [1:0]            quad_d;
    logic                  strobe_q;
    logic                  timeout_q;
    logic [7:0]            cnt_q;

    function automatic logic signed [c_w-1:0] sat_neg(input logic signed [c_w-1:0] v);
        return (v == c_min) ? c_max : -v;
    endfunction

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_push  = bus.data_in_valid_i && !w_full;
    assign w_pop   = (state_q == S_IDLE) && !pend_q && !w_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_x_q[wr_ptr_q[c_aw-1:0]] <= bus.x_i;
            mem_y_q[wr_ptr_q[c_aw-1:0]] <= bus.y_i;
            mem_z_q[wr_ptr_q[c_aw-1:0]] <= bus.z_i;
        end
    end

    // Fold angles beyond +/-90 deg back into the core's convergence range.
    always_comb begin
        x_d    = pend_x_q;
        y_d    = pend_y_q;
        z_d    = pend_z_q;
        quad_d = 2'b00;
        if (pend_z_q > c_quarter) begin
            x_d    = sat_neg(pend_y_q);
            y_d    = pend_x_q;
            z_d    = pend_z_q - c_quarter;
            quad_d = 2'b10;
        end else if (pend_z_q < c_neg_quarter) begin
            x_d    = pend_y_q;
            y_d    = sat_neg(pend_x_q);
            z_d    = pend_z_q + c_quarter;
            quad_d = 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            pend_z_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            quad_q    <= 2'b00;
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_pw'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_pw'(1);
                pend_q   <= 1'b1;
                pend_x_q <= mem_x_q[rd_ptr_q[c_aw-1:0]];
                pend_y_q <= mem_y_q[rd_ptr_q[c_aw-1:0]];
                pend_z_q <= mem_z_q[rd_ptr_q[c_aw-1:0]];
            end
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        x_q      <= x_d;
                        y_q      <= y_d;
                        z_q      <= z_d;
                        quad_q   <= quad_d;
                        strobe_q <= 1'b1;
                        pend_q   <= 1'b0;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt_q counts completed WAIT cycles; the TIMEOUT_CYCLES-th is the limit cycle.
                    if (bus.core_done_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == c_tmo_last) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o                 = !w_full;
    assign bus.x_o                     = x_q;
    assign bus.y_o                     = y_q;
    assign bus.z_o                     = z_q;
    assign bus.quadrant_o              = quad_q;
    assign bus.data_out_valid_strobe_o = strobe_q;
    assign bus.timeout_o               = timeout_q;
    assign bus.busy_o                  = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_cordic_input_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cordic_input_sequencer -- directed self-checking bench for the sequencer.
// Rev 1.0
// ============================================================================
module tb_cordic_input_sequencer;
    logic clk_i;
    logic rst_i;
    int   n_vec;
    int   n_err;

    typedef struct {
        int x; int y; int z;
        int ex; int ey; int ez; int eq;
    } vec_t;

    cordic_input_sequencer_if #(.N_FRAC(7)) bus ();

    cordic_input_sequencer #(
        .N_FRAC(7),
        .FIFO_DEPTH(2),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic push(input int x, input int y, input int z);
        bus.x_i = 8'(x);
        bus.y_i = 8'(y);
        bus.z_i = 8'(z);
        bus.data_in_valid_i = 1'b1;
        step();
        bus.data_in_valid_i = 1'b0;
    endtask

    task automatic wait_strobe(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.data_out_valid_strobe_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Called while the op is in ISSUE: move into WAIT, then pulse done.
    task automatic complete_op();
        step();
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.x_i = 8'sd5;
        bus.y_i = 8'sd6;
        bus.z_i = 8'sd7;
        bus.data_in_valid_i = 1'b1;
        step();
        step();
        bus.data_in_valid_i = 1'b0;
        rst_i = 1'b0;
        n_vec++;
        if (bus.x_o !== 8'd0 || bus.y_o !== 8'd0 || bus.z_o !== 8'd0 || bus.quadrant_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_data: x=%0d y=%0d z=%0d q=%b, required 0 0 0 00",
                     bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o);
        end
        n_vec++;
        if (bus.data_out_valid_strobe_o !== 1'b0 || bus.timeout_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctrl: strobe=%b timeout=%b busy=%b ready=%b, required 0 0 0 1",
                     bus.data_out_valid_strobe_o, bus.timeout_o, bus.busy_o, bus.ready_o);
        end
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.data_out_valid_strobe_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_push_ignored: cycle %0d strobe=%b busy=%b, required 0 0",
                         i, bus.data_out_valid_strobe_o, bus.busy_o);
            end
            step();
        end
    endtask

    task automatic test_passthrough();
        push(40, 0, 32);
        step();
        n_vec++;
        if (bus.data_out_valid_strobe_o !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: strobe=%b one cycle after push, required 0",
                     bus.data_out_valid_strobe_o);
        end
        step();
        n_vec++;
        if (bus.data_out_valid_strobe_o !== 1'b1) begin
            n_err++;
            $display("FAIL latency: strobe=%b two cycles after push, required 1",
                     bus.data_out_valid_strobe_o);
        end
        n_vec++;
        if (bus.x_o !== 8'sd40 || bus.y_o !== 8'sd0 || bus.z_o !== 8'sd32 ||
            bus.quadrant_o !== 2'b00 || bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL passthrough: x=%0d y=%0d z=%0d q=%b busy=%b, required 40 0 32 00 1",
                     bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o, bus.busy_o);
        end
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.busy_o !== 1'b1 || bus.data_out_valid_strobe_o !== 1'b0) begin
                n_err++;
                $display("FAIL busy_hold: cycle %0d busy=%b strobe=%b, required 1 0",
                         i, bus.busy_o, bus.data_out_valid_strobe_o);
            end
            step();
        end
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.quadrant_o !== 2'b00 || bus.x_o !== 8'sd40) begin
            n_err++;
            $display("FAIL done_return: busy=%b q=%b x=%0d, required 0 00 40",
                     bus.busy_o, bus.quadrant_o, bus.x_o);
        end
    endtask

    task automatic test_prerotation();
        vec_t tbl [9];
        bit   found;
        tbl = '{
            '{50, 20, 100, -20, 50, 36, 2},
            '{50, -128, -100, -128, -50, -36, 1},
            '{10, -128, 80, 127, 10, 16, 2},
            '{-128, 5, -128, 5, 127, -64, 1},
            '{7, -9, 64, 7, -9, 64, 0},
            '{7, -9, -64, 7, -9, -64, 0},
            '{-3, 4, 65, -4, -3, 1, 2},
            '{-3, 4, -65, 4, 3, -1, 1},
            '{-128, -128, 127, 127, -128, 63, 2}
        };
        for (int i = 0; i < 9; i++) begin
            push(tbl[i].x, tbl[i].y, tbl[i].z);
            wait_strobe(found);
            n_vec++;
            if (!found || bus.x_o !== 8'(tbl[i].ex) || bus.y_o !== 8'(tbl[i].ey) ||
                bus.z_o !== 8'(tbl[i].ez) || bus.quadrant_o !== 2'(tbl[i].eq)) begin
                n_err++;
                $display("FAIL prerot[%0d]: strobe=%b x=%0d y=%0d z=%0d q=%0d, required x=%0d y=%0d z=%0d q=%0d",
                         i, found, bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o,
                         tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].eq);
            end
            complete_op();
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        int strobes;
        push(30, 40, 10);
        wait_strobe(found);
        step();
        n_vec++;
        if (!found || bus.x_o !== 8'sd30 || bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: strobe=%b x=%0d busy=%b, required 1 30 1", found, bus.x_o, bus.busy_o);
        end
        bus.x_i = 8'sd1; bus.y_i = 8'sd2; bus.z_i = 8'sd3;
        bus.data_in_valid_i = 1'b1;
        step();
        n_vec++;
        if (bus.ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_one_entry: ready=%b, required 1", bus.ready_o);
        end
        bus.x_i = 8'sd4; bus.y_i = 8'sd5; bus.z_i = 8'sd100;
        step();
        n_vec++;
        if (bus.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: ready=%b, required 0", bus.ready_o);
        end
        bus.x_i = 8'sd9; bus.y_i = 8'sd9; bus.z_i = 8'sd9;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.ready_o !== 1'b0 || bus.data_out_valid_strobe_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: ready=%b strobe=%b busy=%b, required 0 0 1",
                         i, bus.ready_o, bus.data_out_valid_strobe_o, bus.busy_o);
            end
        end
        bus.data_in_valid_i = 1'b0;
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        wait_strobe(found);
        n_vec++;
        if (!found || bus.x_o !== 8'sd1 || bus.y_o !== 8'sd2 || bus.z_o !== 8'sd3 ||
            bus.quadrant_o !== 2'b00 || bus.ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: strobe=%b x=%0d y=%0d z=%0d q=%b ready=%b, required 1 1 2 3 00 1",
                     found, bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o, bus.ready_o);
        end
        complete_op();
        wait_strobe(found);
        n_vec++;
        if (!found || bus.x_o !== -8'sd5 || bus.y_o !== 8'sd4 || bus.z_o !== 8'sd36 ||
            bus.quadrant_o !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_third: strobe=%b x=%0d y=%0d z=%0d q=%b, required 1 -5 4 36 10",
                     found, bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o);
        end
        complete_op();
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.data_out_valid_strobe_o === 1'b1) strobes++;
        end
        n_vec++;
        if (strobes != 0) begin
            n_err++;
            $display("FAIL b2b_dropped: %0d extra strobes, required 0", strobes);
        end
    endtask

    task automatic test_timeout();
        bit found;
        bus.x_i = 8'sd11; bus.y_i = 8'sd12; bus.z_i = 8'sd13;
        bus.data_in_valid_i = 1'b1;
        step();
        bus.x_i = -8'sd20; bus.y_i = 8'sd30; bus.z_i = -8'sd90;
        step();
        bus.data_in_valid_i = 1'b0;
        wait_strobe(found);
        n_vec++;
        if (!found || bus.x_o !== 8'sd11 || bus.z_o !== 8'sd13) begin
            n_err++;
            $display("FAIL tmo_issue: strobe=%b x=%0d z=%0d, required 1 11 13", found, bus.x_o, bus.z_o);
        end
        for (int k = 1; k <= 15; k++) begin
            step();
            n_vec++;
            if (bus.timeout_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL tmo_wait[%0d]: timeout=%b busy=%b, required 0 1", k, bus.timeout_o, bus.busy_o);
            end
        end
        step();
        n_vec++;
        if (bus.timeout_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_pulse: timeout=%b busy=%b, required 1 0", bus.timeout_o, bus.busy_o);
        end
        step();
        n_vec++;
        if (bus.timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_one_cycle: timeout=%b, required 0", bus.timeout_o);
        end
        wait_strobe(found);
        n_vec++;
        if (!found || bus.x_o !== 8'sd30 || bus.y_o !== 8'sd20 || bus.z_o !== -8'sd26 ||
            bus.quadrant_o !== 2'b01) begin
            n_err++;
            $display("FAIL tmo_next: strobe=%b x=%0d y=%0d z=%0d q=%b, required 1 30 20 -26 01",
                     found, bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o);
        end
        complete_op();
    endtask

    task automatic test_done_at_limit();
        bit found;
        push(1, 1, 1);
        wait_strobe(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL limit_issue: strobe=%b, required 1", found);
        end
        for (int k = 1; k <= 15; k++) step();
        n_vec++;
        if (bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL limit_cycle: busy=%b timeout=%b, required 1 0", bus.busy_o, bus.timeout_o);
        end
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
        n_vec++;
        if (bus.timeout_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL limit_done: timeout=%b busy=%b, required 0 0", bus.timeout_o, bus.busy_o);
        end
        step();
        n_vec++;
        if (bus.timeout_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL limit_after: timeout=%b busy=%b, required 0 0", bus.timeout_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit found;
        int strobes;
        push(60, 0, 0);
        wait_strobe(found);
        step();
        bus.x_i = 8'sd21; bus.y_i = 8'sd22; bus.z_i = 8'sd23;
        bus.data_in_valid_i = 1'b1;
        step();
        step();
        bus.data_in_valid_i = 1'b0;
        n_vec++;
        if (!found || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_setup: strobe=%b ready=%b busy=%b, required 1 0 1",
                     found, bus.ready_o, bus.busy_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_vec++;
        if (bus.x_o !== 8'd0 || bus.y_o !== 8'd0 || bus.z_o !== 8'd0 || bus.quadrant_o !== 2'b00 ||
            bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b0 || bus.ready_o !== 1'b1 ||
            bus.data_out_valid_strobe_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: x=%0d y=%0d z=%0d q=%b busy=%b tmo=%b ready=%b strobe=%b, required 0 0 0 00 0 0 1 0",
                     bus.x_o, bus.y_o, bus.z_o, bus.quadrant_o, bus.busy_o, bus.timeout_o,
                     bus.ready_o, bus.data_out_valid_strobe_o);
        end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.data_out_valid_strobe_o === 1'b1 || bus.busy_o === 1'b1) strobes++;
        end
        n_vec++;
        if (strobes != 0) begin
            n_err++;
            $display("FAIL rst_mid_flush: %0d cycles with strobe/busy after reset, required 0", strobes);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b1;
        bus.x_i = '0;
        bus.y_i = '0;
        bus.z_i = '0;
        bus.data_in_valid_i = 1'b0;
        bus.core_done_i = 1'b0;
        step();
        test_reset();
        test_passthrough();
        test_prerotation();
        test_back_to_back();
        test_timeout();
        test_done_at_limit();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
